switch_egress_port: RTL and testbench
=====================================

// Module: switch_egress_port
// PURPOSE
//   Receive end of the sorting-network lane: accepts tagged words {valid, port, data} for one output port.
//   Buffers matching words in a FIFO and presents them on a valid/ready stream to the output-port logic.
//   Raises almost_full back toward the scheduler; counts dropped words. One instance per network output lane.
// PARAMETERS
//   DATA_WIDTH  128  payload width in bits
//   PORT_NUB    16   number of switch ports; tag width PW = $clog2(PORT_NUB)
//   PORT_ID     0    index of this output port, range 0..PORT_NUB-1
//   FIFO_DEPTH  8    FIFO entries; power of two, >= 4
//   CNT_WIDTH   16   width of the statistics counters
// PORTS
//   clk           in   1                   clock; all logic on its rising edge
//   rst           in   1                   synchronous active-high reset
//   lane_in       in   PW+1+DATA_WIDTH     network word {valid[MSB], port[PW-1:0], data[DATA_WIDTH-1:0]}
//   almost_full   out  1                   backpressure hint to the scheduler
//   m_valid       out  1                   output word available
//   m_ready       in   1                   output consumer accepts the word
//   m_data        out  DATA_WIDTH          payload at the FIFO head
//   fifo_level    out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
//   drop_cnt      out  CNT_WIDTH           words dropped because the FIFO was full
//   misroute_cnt  out  CNT_WIDTH           valid words tagged for another port (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: wr_ptr = rd_ptr = 0, fifo_level = 0, m_valid = 0, m_data = 0, almost_full = 0, all counters = 0.
//     FIFO storage is not reset. Reset mid-traffic discards all buffered words immediately.
//   - Classification, every cycle, from the combinational decode of lane_in:
//       hit      = valid & (port == PORT_ID)
//       misroute = valid & (port != PORT_ID)
//       valid=0  -> idle word; ignored, nothing is counted.
//   - pop = m_valid & m_ready.
//   - push = hit & (fifo_level < FIFO_DEPTH | pop).
//     A simultaneous pop frees the slot, so a full FIFO still accepts a hit in the same cycle.
//   - Drop: hit & ~push. The word is discarded and drop_cnt increments, saturating at all ones.
//   - Misroute: the word is never written to the FIFO.
//   - fifo_level update: push & ~pop -> +1; pop & ~push -> -1; both or neither -> unchanged.
//   - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally modulo FIFO_DEPTH.
//   - Latency: a hit sampled at edge N appears at the output with m_valid = 1 after edge N (one cycle).
//   - Output is first-word-fall-through: m_data = mem[rd_ptr] when m_valid, else 0. m_valid = (fifo_level != 0).
//   - m_data is held stable while m_valid & ~m_ready. Payload bits are never inspected.
//   - almost_full is a registered output: almost_full = (next fifo_level >= FIFO_DEPTH-2).
//     This margin covers the registered network stage between scheduler and egress.
//   - No FSM beyond the FIFO state; throughput is one word per cycle in and out.
// CONFIGURATION
//   - SWITCH_EGRESS_MISROUTE_EN defined:
//       misroute_cnt increments, saturating, on every misroute word.
//   - SWITCH_EGRESS_MISROUTE_EN undefined:
//       misroute_cnt is tied to 0 and no counter logic is built.
//       Misroute words are still discarded.
// STRUCTURE
//   - Package switch_pkg holds:
//       PW and network word width functions of PORT_NUB/DATA_WIDTH;
//       field offsets VALID_BIT, PORT_LSB, DATA_LSB;
//       shared by the network stages and this block.
//   - One sub-module, switch_egress_fifo: parameterised sync FIFO with push/pop/level, FWFT read.
//     Classification, counters and almost_full stay in the top module.
// TESTING
//   1 Reset is held 3 cycles while lane_in carries valid hits
//     -> all outputs stay 0; the first hit after reset release emerges 1 cycle later.
//   2 PORT_ID=5, 4 hits with data 0x1..0x4, m_ready=1
//     -> m_data sequence 0x1,0x2,0x3,0x4 with one cycle latency; fifo_level never exceeds 1.
//   3 m_ready=0, 10 consecutive hits, FIFO_DEPTH=8
//     -> fifo_level=8; drop_cnt=2; almost_full asserts on the edge where level reaches 6.
//   4 FIFO full, hit and m_ready=1 in the same cycle
//     -> the word is accepted; level stays 8; drop_cnt unchanged.
//   5 Valid word tagged port 3 into PORT_ID=5, plus an idle word (valid=0) with port=5
//     -> neither is written; misroute_cnt=1 with the macro, 0 without; drop_cnt=0.
//   6 Drive drop_cnt to saturation (CNT_WIDTH=4, 20 drops) -> counter holds at 15.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared network-word layout helpers for the switch lane stages.
// Word layout: {valid[MSB], port[PW-1:0], data[DATA_WIDTH-1:0]}.
package switch_pkg;

   // Port tag width for a given number of switch ports (at least one bit).
   function automatic int unsigned port_w(input int unsigned port_nub);
      return (port_nub > 1) ? $clog2(port_nub) : 1;
   endfunction

   // Total network word width.
   function automatic int unsigned word_w(input int unsigned port_nub, input int unsigned data_w);
      return port_w(port_nub) + 1 + data_w;
   endfunction

   // Bit position of the valid flag.
   function automatic int unsigned valid_bit(input int unsigned port_nub, input int unsigned data_w);
      return port_w(port_nub) + data_w;
   endfunction

   // Lowest bit of the port tag.
   function automatic int unsigned port_lsb(input int unsigned data_w);
      return data_w;
   endfunction

   localparam int unsigned DATA_LSB = 0;

endpackage

// File: rtl/switch_egress_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level.
// Caller guarantees no push when full without a pop, and no pop when empty.
module switch_egress_fifo #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic                            pop,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   output logic                            rd_valid,
   output logic [DATA_WIDTH-1:0]           rd_data,
   output logic [$clog2(FIFO_DEPTH):0]     level,
   output logic [$clog2(FIFO_DEPTH):0]     level_nxt_c
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;

   // Next occupancy: simultaneous push and pop cancel.
   always_comb begin
      level_nxt_c = level;
      if (push && !pop)
         level_nxt_c = level + LW'(1);
      else if (pop && !push)
         level_nxt_c = level - LW'(1);
   end

   // Pointer and level registers; pointers wrap modulo depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt_c;
      end
   end

   // Storage write; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   assign rd_valid = (level != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/switch_egress_port.sv
// Egress end of a sorting-network lane: filters words for PORT_ID into a FWFT FIFO,
// drives a valid/ready stream, almost_full backpressure and drop/misroute counters.
// Optional macro SWITCH_EGRESS_MISROUTE_EN enables the saturating misroute counter;
// without it misroute_cnt is tied to zero.
module switch_egress_port
   import switch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned PORT_NUB   = 16,
   parameter int unsigned PORT_ID    = 0,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [word_w(PORT_NUB, DATA_WIDTH)-1:0]   lane_in,
   output logic                                      almost_full,
   output logic                                      m_valid,
   input  logic                                      m_ready,
   output logic [DATA_WIDTH-1:0]                     m_data,
   output logic [$clog2(FIFO_DEPTH):0]               fifo_level,
   output logic [CNT_WIDTH-1:0]                      drop_cnt,
   output logic [CNT_WIDTH-1:0]                      misroute_cnt
);

   localparam int unsigned PW        = port_w(PORT_NUB);
   localparam int unsigned VALID_BIT = valid_bit(PORT_NUB, DATA_WIDTH);
   localparam int unsigned PORT_LSB  = port_lsb(DATA_WIDTH);
   localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1;

   logic                  lane_valid_c;
   logic [PW-1:0]         lane_port_c;
   logic [DATA_WIDTH-1:0] lane_data_c;
   logic                  hit_c;
   logic                  pop_c;
   logic                  push_c;
   logic                  drop_c;
   logic [LW-1:0]         level_nxt_c;

   // Field decode and classification of the incoming network word.
   always_comb begin
      lane_valid_c = lane_in[VALID_BIT];
      lane_port_c  = lane_in[PORT_LSB +: PW];
      lane_data_c  = lane_in[DATA_LSB +: DATA_WIDTH];
      hit_c        = lane_valid_c && (lane_port_c == PW'(PORT_ID));
      pop_c        = m_valid && m_ready;
      push_c       = hit_c && ((fifo_level < LW'(FIFO_DEPTH)) || pop_c);
      drop_c       = hit_c && !push_c;
   end

   switch_egress_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push_c),
      .pop         (pop_c),
      .wr_data     (lane_data_c),
      .rd_valid    (m_valid),
      .rd_data     (m_data),
      .level       (fifo_level),
      .level_nxt_c (level_nxt_c)
   );

   // Backpressure from next occupancy; two slots of margin for the network register stage.
   always_ff @(posedge clk) begin
      if (rst)
         almost_full <= 1'b0;
      else
         almost_full <= (level_nxt_c >= LW'(FIFO_DEPTH - 2));
   end

   // Saturating count of hits lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= '0;
      else if (drop_c && (drop_cnt != '1))
         drop_cnt <= drop_cnt + CNT_WIDTH'(1);
   end

`ifdef SWITCH_EGRESS_MISROUTE_EN
   logic misroute_c;
   assign misroute_c = lane_valid_c && (lane_port_c != PW'(PORT_ID));

   // Saturating count of valid words tagged for another port.
   always_ff @(posedge clk) begin
      if (rst)
         misroute_cnt <= '0;
      else if (misroute_c && (misroute_cnt != '1))
         misroute_cnt <= misroute_cnt + CNT_WIDTH'(1);
   end
`else
   assign misroute_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_egress_port.sv
// Scoreboard bench for switch_egress_port (PORT_ID=5, depth 8, 4-bit counters).
module tb_switch_egress_port;

   localparam int unsigned DW    = 32;
   localparam int unsigned PN    = 16;
   localparam int unsigned PID   = 5;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 4;
   localparam int unsigned PW    = 4;
   localparam int unsigned WW    = PW + 1 + DW;
   localparam int unsigned LW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [WW-1:0] lane_in;
   logic          almost_full;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [LW-1:0] fifo_level;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] misroute_cnt;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [DW-1:0] sb [$];
   int            mdl_level;
   int            exp_drop;
   logic          exp_af;
   logic          popped;
   logic [DW-1:0] pop_exp;
   logic [DW-1:0] pop_act;

   switch_egress_port #(
      .DATA_WIDTH (DW),
      .PORT_NUB   (PN),
      .PORT_ID    (PID),
      .FIFO_DEPTH (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .lane_in      (lane_in),
      .almost_full  (almost_full),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .fifo_level   (fifo_level),
      .drop_cnt     (drop_cnt),
      .misroute_cnt (misroute_cnt)
   );

   always #5 clk = ~clk;

   // Drive one cycle from the negedge, update the model, return at the next negedge.
   task automatic drive(input logic v, input logic [PW-1:0] port, input logic [DW-1:0] data, input logic rdy);
      logic hit, pop, push;
      lane_in = {v, port, data};
      m_ready = rdy;
      popped  = 1'b0;
      if (!rst) begin
         hit  = v && (port == PW'(PID));
         pop  = (mdl_level != 0) && rdy;
         push = hit && ((mdl_level < int'(DEPTH)) || pop);
         if (pop && sb.size() != 0) begin
            popped  = 1'b1;
            pop_exp = sb.pop_front();
            pop_act = m_data;
         end
         if (push && !pop) mdl_level++;
         else if (pop && !push) mdl_level--;
         if (push) sb.push_back(data);
         if (hit && !push && exp_drop < 15) exp_drop++;
         exp_af = (mdl_level >= int'(DEPTH) - 2);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_model();
      sb.delete();
      mdl_level = 0;
      exp_drop  = 0;
      exp_af    = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      drive(1'b0, '0, '0, 1'b0);
      rst = 1'b0;
      clear_model();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, PW'(PID), DW'(32'hA0 + i), 1'b1);
         checks++;
         if ({m_valid, almost_full, fifo_level, drop_cnt, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d: valid=%b af=%b lvl=%0d drop=%0d data=%h, want all 0",
                     i, m_valid, almost_full, fifo_level, drop_cnt, m_data);
         end
      end
      rst = 1'b0;
      clear_model();
      drive(1'b1, PW'(PID), 32'h0000_00AB, 1'b0);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'h0000_00AB || fifo_level !== LW'(1)) begin
         errors++;
         $display("FAIL reset_first_hit: valid=%b data=%h lvl=%0d, want 1 000000ab 1", m_valid, m_data, fifo_level);
      end
      drive(1'b0, '0, '0, 1'b1);
      checks++;
      if (!popped || pop_act !== pop_exp) begin
         errors++;
         $display("FAIL reset_pop: got %h want %h (popped=%b)", pop_act, pop_exp, popped);
      end
   endtask

   task automatic test_stream();
      apply_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, PW'(PID), DW'(i), 1'b1);
         checks++;
         if (m_valid !== 1'b1 || m_data !== DW'(i)) begin
            errors++;
            $display("FAIL stream_latency word %0d: valid=%b data=%h want 1 %h", i, m_valid, m_data, DW'(i));
         end
         checks++;
         if (fifo_level > LW'(1)) begin
            errors++;
            $display("FAIL stream_level word %0d: lvl=%0d want <=1", i, fifo_level);
         end
         if (popped) begin
            checks++;
            if (pop_act !== pop_exp) begin
               errors++;
               $display("FAIL stream_order: got %h want %h", pop_act, pop_exp);
            end
         end
      end
      drive(1'b0, '0, '0, 1'b1);
      checks++;
      if (!popped || pop_act !== 32'h4 || fifo_level !== '0) begin
         errors++;
         $display("FAIL stream_last: got %h lvl=%0d popped=%b, want 00000004 0 1", pop_act, fifo_level, popped);
      end
   endtask

   task automatic test_fill();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, PW'(PID), DW'(32'h100 + i), 1'b0);
         checks++;
         if (fifo_level !== LW'(mdl_level) || almost_full !== exp_af) begin
            errors++;
            $display("FAIL fill_step %0d: lvl=%0d af=%b want %0d %b", i, fifo_level, almost_full, mdl_level, exp_af);
         end
         if (i == 4 || i == 5) begin
            checks++;
            if (almost_full !== (i == 5)) begin
               errors++;
               $display("FAIL fill_af_edge %0d: af=%b want %b", i, almost_full, (i == 5));
            end
         end
      end
      checks++;
      if (fifo_level !== LW'(8) || drop_cnt !== CW'(2)) begin
         errors++;
         $display("FAIL fill_end: lvl=%0d drop=%0d want 8 2", fifo_level, drop_cnt);
      end
   endtask

   task automatic test_full_pass();
      int n;
      drive(1'b1, PW'(PID), 32'h999, 1'b1);
      checks++;
      if (!popped || pop_act !== 32'h100) begin
         errors++;
         $display("FAIL full_pass_head: got %h want 00000100", pop_act);
      end
      checks++;
      if (fifo_level !== LW'(8) || drop_cnt !== CW'(2)) begin
         errors++;
         $display("FAIL full_pass_accept: lvl=%0d drop=%0d want 8 2", fifo_level, drop_cnt);
      end
      n = 0;
      while (m_valid && n < 20) begin
         drive(1'b0, '0, '0, 1'b1);
         n++;
         checks++;
         if (!popped || pop_act !== pop_exp) begin
            errors++;
            $display("FAIL drain_order %0d: got %h want %h", n, pop_act, pop_exp);
         end
      end
      checks++;
      if (n != 8 || pop_exp !== 32'h999 || fifo_level !== '0 || almost_full !== 1'b0) begin
         errors++;
         $display("FAIL drain_end: pops=%0d last=%h lvl=%0d af=%b want 8 00000999 0 0",
                  n, pop_exp, fifo_level, almost_full);
      end
   endtask

   task automatic test_misroute();
      logic [CW-1:0] want_mis;
`ifdef SWITCH_EGRESS_MISROUTE_EN
      want_mis = CW'(1);
`else
      want_mis = CW'(0);
`endif
      apply_reset();
      drive(1'b1, PW'(3), 32'h33, 1'b1);
      drive(1'b0, PW'(PID), 32'h55, 1'b1);
      checks++;
      if (m_valid !== 1'b0 || fifo_level !== '0 || drop_cnt !== '0) begin
         errors++;
         $display("FAIL misroute_nowrite: valid=%b lvl=%0d drop=%0d want 0 0 0", m_valid, fifo_level, drop_cnt);
      end
      checks++;
      if (misroute_cnt !== want_mis) begin
         errors++;
         $display("FAIL misroute_cnt: got %0d want %0d", misroute_cnt, want_mis);
      end
   endtask

   task automatic test_drop_sat();
      int n;
      apply_reset();
      for (int i = 0; i < 28; i++) begin
         drive(1'b1, PW'(PID), DW'(i), 1'b0);
         checks++;
         if (drop_cnt !== CW'(exp_drop)) begin
            errors++;
            $display("FAIL drop_step %0d: got %0d want %0d", i, drop_cnt, exp_drop);
         end
      end
      checks++;
      if (drop_cnt !== 4'hF) begin
         errors++;
         $display("FAIL drop_sat: got %0d want 15", drop_cnt);
      end
      n = 0;
      while (m_valid && n < 20) begin
         drive(1'b0, '0, '0, 1'b1);
         n++;
      end
      checks++;
      if (n != 8 || pop_exp !== 32'h7 || drop_cnt !== 4'hF) begin
         errors++;
         $display("FAIL drop_drain: pops=%0d last=%h drop=%0d want 8 00000007 15", n, pop_exp, drop_cnt);
      end
   endtask

   initial begin
      rst     = 1'b1;
      lane_in = '0;
      m_ready = 1'b0;
      clear_model();
      popped  = 1'b0;
      pop_exp = '0;
      pop_act = '0;
      test_reset();
      test_stream();
      test_fill();
      test_full_pass();
      test_misroute();
      test_drop_sat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
